// File: rtl/digital_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : digital_timer_ctrl
// Description : Push-button front end for digital_timer. Synchronises and
//               debounces btn_start / btn_clear, classifies clear presses as
//               short or long, and drives the timer pause level plus the
//               clear / reset command pulses from a three-state FSM.
// Options     : `define DTC_LOCK_EN adds the ctrl_lock input, which freezes
//               the controller while asserted.
// Revision    : 1.0 - initial release
// ============================================================================
module digital_timer_ctrl #(
    parameter int DEBOUNCE_CYCLES   = 1000,   // >= 2
    parameter int LONG_PRESS_CYCLES = 50000   // > DEBOUNCE_CYCLES
) (
    input  logic       sys_clk,
    input  logic       rst_b,
    input  logic       btn_start,
    input  logic       btn_clear,
`ifdef DTC_LOCK_EN
    input  logic       ctrl_lock,
`endif
    output logic       timer_pause,
    output logic       timer_clear,
    output logic       timer_reset,
    output logic [1:0] ctrl_state
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int C_DB_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int C_HOLD_W    = $clog2(LONG_PRESS_CYCLES + 1);
    localparam int C_BTN_START = 0;
    localparam int C_BTN_CLEAR = 1;

    localparam logic [C_DB_W-1:0]   C_DB_ONE    = C_DB_W'(1);
    localparam logic [C_DB_W-1:0]   C_DB_LAST   = C_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [C_HOLD_W-1:0] C_HOLD_ONE  = C_HOLD_W'(1);
    localparam logic [C_HOLD_W-1:0] C_HOLD_MAX  = C_HOLD_W'(LONG_PRESS_CYCLES);
    localparam logic [C_HOLD_W-1:0] C_HOLD_LAST = C_HOLD_W'(LONG_PRESS_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUNNING = 2'b01,
        ST_PAUSED  = 2'b10
    } state_e;

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic [1:0]          sync1_q;
    logic [1:0]          sync2_q;
    logic [1:0]          w_db;
    logic [1:0]          db_dly_q;
    logic [1:0]          w_rise;
    logic [1:0]          w_fall;
    logic                w_lock;

    logic [C_HOLD_W-1:0] hold_q;
    logic [C_HOLD_W-1:0] hold_d;
    logic                long_done_q;
    logic                long_done_d;

    logic                w_long_evt;
    logic                w_short_evt;
    logic                w_start_evt;

    state_e              state_q;
    state_e              state_d;
    logic                pause_q;
    logic                pause_d;
    logic                clear_q;
    logic                clear_d;
    logic                reset_q;
    logic                reset_d;

    // ------------------------------------------------------------------------
    // Lock input (frozen to 0 when the option is not built)
    // ------------------------------------------------------------------------
`ifdef DTC_LOCK_EN
    assign w_lock = ctrl_lock;
`else
    assign w_lock = 1'b0;
`endif

    // Two-flop synchroniser; the only logic that samples the raw buttons.
    always_ff @(posedge sys_clk or negedge rst_b) begin
        if (!rst_b) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= {btn_clear, btn_start};
            sync2_q <= sync1_q;
        end
    end

    // ------------------------------------------------------------------------
    // Debouncers: the level only follows the synchronised input after it has
    // disagreed for DEBOUNCE_CYCLES consecutive cycles.
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < 2; gi++) begin : g_debounce
        logic [C_DB_W-1:0] cnt_q;
        logic [C_DB_W-1:0] cnt_d;
        logic              db_q;
        logic              db_d;

        // Count disagreement cycles, adopt the new level on the last one.
        always_comb begin
            cnt_d = cnt_q;
            db_d  = db_q;
            if (sync2_q[gi] == db_q) begin
                cnt_d = '0;
            end else if (cnt_q == C_DB_LAST) begin
                db_d  = sync2_q[gi];
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + C_DB_ONE;
            end
        end

        // Debounce counter and level registers.
        always_ff @(posedge sys_clk or negedge rst_b) begin
            if (!rst_b) begin
                cnt_q <= '0;
                db_q  <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                db_q  <= db_d;
            end
        end

        assign w_db[gi] = db_q;
    end

    // Delayed debounced levels for edge detection.
    always_ff @(posedge sys_clk or negedge rst_b) begin
        if (!rst_b) begin
            db_dly_q <= 2'b00;
        end else begin
            db_dly_q <= w_db;
        end
    end

    assign w_rise = w_db & ~db_dly_q;
    assign w_fall = ~w_db & db_dly_q;

    // ------------------------------------------------------------------------
    // Clear-press classification
    // ------------------------------------------------------------------------

    // Hold timer: counts debounced clear high-time, saturating, zero when
    // released or locked.
    always_comb begin
        hold_d = hold_q;
        if (!w_db[C_BTN_CLEAR] || w_lock) begin
            hold_d = '0;
        end else if (hold_q != C_HOLD_MAX) begin
            hold_d = hold_q + C_HOLD_ONE;
        end
    end

    // The long event fires on the increment that reaches the threshold, so it
    // can only happen once per press thanks to saturation.
    assign w_long_evt  = w_db[C_BTN_CLEAR] & ~w_lock & (hold_q == C_HOLD_LAST);

    // A release after a long press has already been consumed by the reset.
    assign w_short_evt = w_fall[C_BTN_CLEAR] & ~long_done_q & ~w_lock;

    // A clear press owns the controls from its debounced rise through its
    // release cycle, so a start edge inside that window is dropped.
    assign w_start_evt = w_rise[C_BTN_START] & ~w_db[C_BTN_CLEAR] &
                         ~w_fall[C_BTN_CLEAR] & ~w_lock;

    // Remember that the current press already produced a long event.
    always_comb begin
        long_done_d = long_done_q;
        if (w_long_evt) begin
            long_done_d = 1'b1;
        end else if (w_fall[C_BTN_CLEAR]) begin
            long_done_d = 1'b0;
        end
    end

    // Hold timer and long-press flag registers.
    always_ff @(posedge sys_clk or negedge rst_b) begin
        if (!rst_b) begin
            hold_q      <= '0;
            long_done_q <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            long_done_q <= long_done_d;
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM. Priority: long > short clear > start; losers are dropped.
    // ------------------------------------------------------------------------

    // Next state and registered outputs; pulses default low every cycle.
    always_comb begin
        state_d = state_q;
        pause_d = pause_q;
        clear_d = 1'b0;
        reset_d = 1'b0;
        if (w_long_evt) begin
            state_d = ST_IDLE;
            pause_d = 1'b1;
            reset_d = 1'b1;
        end else if (w_short_evt) begin
            case (state_q)
                ST_IDLE: begin
                    clear_d = 1'b1;
                end
                ST_PAUSED: begin
                    state_d = ST_IDLE;
                    pause_d = 1'b1;
                    clear_d = 1'b1;
                end
                ST_RUNNING: begin
                    // Clearing a running count is not allowed.
                end
                default: begin
                    state_d = ST_IDLE;
                    pause_d = 1'b1;
                end
            endcase
        end else if (w_start_evt) begin
            case (state_q)
                ST_IDLE, ST_PAUSED: begin
                    state_d = ST_RUNNING;
                    pause_d = 1'b0;
                end
                ST_RUNNING: begin
                    state_d = ST_PAUSED;
                    pause_d = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                    pause_d = 1'b1;
                end
            endcase
        end else if (state_q != ST_IDLE && state_q != ST_RUNNING &&
                     state_q != ST_PAUSED) begin
            // Recover from the unused encoding.
            state_d = ST_IDLE;
            pause_d = 1'b1;
        end
    end

    // FSM state and output registers.
    always_ff @(posedge sys_clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= ST_IDLE;
            pause_q <= 1'b1;
            clear_q <= 1'b0;
            reset_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pause_q <= pause_d;
            clear_q <= clear_d;
            reset_q <= reset_d;
        end
    end

    assign ctrl_state  = state_q;
    assign timer_pause = pause_q;
    assign timer_clear = clear_q;
    assign timer_reset = reset_q;

endmodule
`default_nettype wire

// File: tb/tb_digital_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_digital_timer_ctrl
// Description : Self-checking bench for digital_timer_ctrl with a scoreboard
//               fed by a behavioural model and a decoupled output monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_digital_timer_ctrl;

    localparam int D = 4;
    localparam int L = 20;

    logic       sys_clk   = 1'b0;
    logic       rst_b     = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_clear = 1'b0;
`ifdef DTC_LOCK_EN
    logic       ctrl_lock = 1'b0;
`endif
    logic       timer_pause;
    logic       timer_clear;
    logic       timer_reset;
    logic [1:0] ctrl_state;

    digital_timer_ctrl #(
        .DEBOUNCE_CYCLES   (D),
        .LONG_PRESS_CYCLES (L)
    ) dut (
        .sys_clk     (sys_clk),
        .rst_b       (rst_b),
        .btn_start   (btn_start),
        .btn_clear   (btn_clear),
`ifdef DTC_LOCK_EN
        .ctrl_lock   (ctrl_lock),
`endif
        .timer_pause (timer_pause),
        .timer_clear (timer_clear),
        .timer_reset (timer_reset),
        .ctrl_state  (ctrl_state)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        int         tag;
        logic [1:0] st;
        logic       p;
        logic       c;
        logic       r;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   n_clr = 0;
    int   n_rst = 0;

    // Behavioural model state
    logic [D-1:0] m_hist [2];
    int           m_n;
    bit   [1:0]   m_db;
    bit   [1:0]   m_prev;
    int           m_hold;
    bit           m_ldone;
    bit   [1:0]   m_st;
    bit           m_p;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s @edge %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: every edge presents one output tuple; compare against the
    // scoreboard entry tagged with that edge.
    always @(negedge sys_clk) begin
        exp_t e;
        if (rst_b) begin
            if (timer_clear) n_clr++;
            if (timer_reset) n_rst++;
            while (sbq.size() > 0 && sbq[0].tag < cyc) begin
                e = sbq.pop_front();
                total++;
                bad++;
                $display("FAIL missed expectation for edge %0d (now %0d)", e.tag, cyc);
            end
            if (sbq.size() > 0 && sbq[0].tag == cyc) begin
                e = sbq.pop_front();
                check("outputs{state,pause,clear,reset}",
                      int'({ctrl_state, timer_pause, timer_clear, timer_reset}),
                      int'({e.st, e.p, e.c, e.r}));
            end
        end
    end

    task automatic model_reset();
        m_hist[0] = '0;
        m_hist[1] = '0;
        m_n       = 0;
        m_db      = 2'b00;
        m_prev    = 2'b00;
        m_hold    = 0;
        m_ldone   = 1'b0;
        m_st      = 2'b00;
        m_p       = 1'b1;
        sbq.delete();
    endtask

    // One raw sample. A button level is accepted once the last D samples all
    // disagree with it; its effect reaches the outputs three edges after the
    // sample that completed the window.
    task automatic model_step(input bit s, input bit c, input int tag);
        bit [1:0] raw;
        bit       rise_s, fall_c, long_e, short_e, start_e, clr, rst;
        exp_t     e;
        raw = {c, s};
        if (m_n < D) m_n++;
        for (int b = 0; b < 2; b++) begin
            m_hist[b] = {m_hist[b][D-2:0], raw[b]};
            if (m_n == D && m_hist[b] == {D{~m_db[b]}}) m_db[b] = ~m_db[b];
        end
        rise_s  = m_db[0] && !m_prev[0];
        fall_c  = !m_db[1] && m_prev[1];
        m_hold  = m_db[1] ? m_hold + 1 : 0;
        long_e  = m_db[1] && (m_hold == L);
        short_e = fall_c && !m_ldone;
        start_e = rise_s && !m_db[1] && !fall_c;
        if (fall_c) m_ldone = 1'b0;
        if (long_e) m_ldone = 1'b1;
        clr = 1'b0;
        rst = 1'b0;
        if (long_e) begin
            m_st = 2'b00; m_p = 1'b1; rst = 1'b1;
        end else if (short_e) begin
            if (m_st == 2'b00) begin
                clr = 1'b1;
            end else if (m_st == 2'b10) begin
                m_st = 2'b00; m_p = 1'b1; clr = 1'b1;
            end
        end else if (start_e) begin
            if (m_st == 2'b01) begin
                m_st = 2'b10; m_p = 1'b1;
            end else begin
                m_st = 2'b01; m_p = 1'b0;
            end
        end
        m_prev = m_db;
        e.tag = tag + 3;
        e.st  = m_st;
        e.p   = m_p;
        e.c   = clr;
        e.r   = rst;
        sbq.push_back(e);
    endtask

    // Called at a falling edge: drive raw levels for the next rising edge.
    task automatic drive(input bit s, input bit c);
        btn_start = s;
        btn_clear = c;
        model_step(s, c, cyc + 1);
        @(negedge sys_clk);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0);
    endtask

    task automatic press(input bit s, input bit c, input int n);
        repeat (n) drive(s, c);
        idle(12);
    endtask

    task automatic release_reset();
        exp_t e;
        rst_b = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            e.tag = cyc + k; e.st = 2'b00; e.p = 1'b1; e.c = 1'b0; e.r = 1'b0;
            sbq.push_back(e);
        end
    endtask

    task automatic check_reset_values(input string tagname);
        check({tagname, " state"}, ctrl_state, 0);
        check({tagname, " pause"}, timer_pause, 1);
        check({tagname, " clear"}, timer_clear, 0);
        check({tagname, " reset"}, timer_reset, 0);
    endtask

    initial begin
        int n0, c0, r0, rel, first;
        bit cs, cc;

        // Reset and idle
        model_reset();
        repeat (3) @(negedge sys_clk);
        check_reset_values("por");
        release_reset();
        idle(10);
        check("idle state", ctrl_state, 0);
        check("idle pause", timer_pause, 1);
        check("idle clear pulses", n_clr, 0);

        // Start held 10 cycles: pause drops D+2 edges after the first sample
        n0 = cyc + 1;
        repeat (10) begin
            drive(1'b1, 1'b0);
            if (cyc == n0 + D + 1) check("latency pause before", timer_pause, 1);
            if (cyc == n0 + D + 2) check("latency pause after", timer_pause, 0);
        end
        idle(12);
        check("run state", ctrl_state, 1);

        // Bouncing start shorter than D: ignored
        repeat (3) drive(1'b1, 1'b0);
        repeat (2) drive(1'b0, 1'b0);
        repeat (3) drive(1'b1, 1'b0);
        idle(12);
        check("bounce state", ctrl_state, 1);
        check("bounce pause", timer_pause, 0);

        // Pause, then short clear -> IDLE with one clear pulse
        press(1'b1, 1'b0, 8);
        check("paused state", ctrl_state, 2);
        c0 = n_clr;
        press(1'b0, 1'b1, 8);
        check("short clear pulses", n_clr - c0, 1);
        check("short clear state", ctrl_state, 0);

        // Short clear while RUNNING is ignored
        press(1'b1, 1'b0, 8);
        c0 = n_clr;
        press(1'b0, 1'b1, 8);
        check("running clear pulses", n_clr - c0, 0);
        check("running clear state", ctrl_state, 1);

        // Long press in RUNNING
        c0 = n_clr;
        r0 = n_rst;
        press(1'b0, 1'b1, 40);
        check("long reset pulses", n_rst - r0, 1);
        check("long clear pulses", n_clr - c0, 0);
        check("long state", ctrl_state, 0);
        check("long pause", timer_pause, 1);

        // Coincident start and clear in PAUSED
        press(1'b1, 1'b0, 8);
        press(1'b1, 1'b0, 8);
        check("pre-coincide state", ctrl_state, 2);
        c0 = n_clr;
        repeat (8) drive(1'b1, 1'b1);
        check("coincide held state", ctrl_state, 2);
        idle(12);
        check("coincide final state", ctrl_state, 0);
        check("coincide clear pulses", n_clr - c0, 1);

        // Reset in the middle of a long press
        press(1'b1, 1'b0, 8);
        repeat (D + 2 + 15) drive(1'b0, 1'b1);
        #2 rst_b = 1'b0;
        #1 check_reset_values("async");
        model_reset();
        repeat (2) @(negedge sys_clk);
        release_reset();
        rel   = cyc;
        first = -1;
        r0    = n_rst;
        repeat (40) begin
            drive(1'b0, 1'b1);
            if (timer_reset && first < 0) first = cyc;
        end
        check("post-reset long edge", first, rel + D + 2 + L);
        idle(12);
        check("post-reset long pulses", n_rst - r0, 1);
        check("post-reset state", ctrl_state, 0);

        // Randomised bouncing buttons against the model
        cs = 1'b0;
        cc = 1'b0;
        repeat (3000) begin
            if ($urandom_range(0, 9) == 0)  cs = ~cs;
            if ($urandom_range(0, 15) == 0) cc = ~cc;
            drive(cs, cc);
        end
        idle(12);
        repeat (4) @(negedge sys_clk);
        check("scoreboard drained", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/digital_timer_ctrl.md
Name: digital_timer_ctrl

Overview:
Front-end controller that drives the `digital_timer` command inputs from two raw push-buttons.
- Inputs are `btn_start` and `btn_clear`. They are synchronised and debounced.
- A short or long press on `btn_clear` is classified by duration.
- A 3-state FSM produces `timer_pause` as a level and `timer_clear` / `timer_reset` as 1-cycle pulses.
- Sits between the board buttons and the `digital_timer` instance, on the same `sys_clk` domain.

Parameters:
- DEBOUNCE_CYCLES, 1000, consecutive stable cycles required before a debounced button level changes (must be ≥2).
- LONG_PRESS_CYCLES, 50000, debounced `btn_clear` high-time, in cycles, that makes a long press (must be > DEBOUNCE_CYCLES).

Ports:
- sys_clk  input  1  system clock; all logic on rising edge.
- rst_b  input  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
- btn_start  input  1  raw start/stop button, asynchronous, active-high, may bounce.
- btn_clear  input  1  raw clear button, asynchronous, active-high, may bounce.
- timer_pause  output  1  level to `digital_timer`; 1 = counting halted.
- timer_clear  output  1  1-cycle pulse; zeroes the timer count.
- timer_reset  output  1  1-cycle pulse; full timer reset.
- ctrl_state  output  2  FSM state: 00 IDLE, 01 RUNNING, 10 PAUSED (11 unused).

Behaviour:
- Reset (rst_b=0, async):
  - Sync flops, debounced levels and counters go to 0.
  - `long_done` flag cleared.
  - Outputs: ctrl_state=IDLE, timer_pause=1, timer_clear=0, timer_reset=0.
- Synchroniser: 2-flop per button (s1, s2). No other logic samples the raw inputs.
- Debounce, per button:
  - Counter clears whenever s2 == db.
  - When s2 != db, the counter increments each cycle.
  - When it would reach DEBOUNCE_CYCLES, db <= s2 and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes db.
- Edge detect: rise/fall are derived from db vs a 1-cycle delayed db.
- Start event = rise of db_start.
- Clear classification:
  - Hold counter counts cycles while db_clear=1 and saturates at LONG_PRESS_CYCLES. It clears when db_clear=0.
  - Hold counter reaching LONG_PRESS_CYCLES while held gives a long event (one cycle). It sets `long_done`.
  - Fall of db_clear with long_done=0 gives a short event.
  - Fall with long_done=1 produces nothing and clears long_done.
- FSM, registered; outputs update on the same edge as the state:
  - IDLE: start → RUNNING, pause=0. Short clear → stay IDLE, emit timer_clear.
  - RUNNING: start → PAUSED, pause=1. Short clear is ignored (count not disturbed).
  - PAUSED: start → RUNNING, pause=0. Short clear → IDLE, emit timer_clear.
  - Any state: long event → IDLE, pause=1, emit timer_reset.
- Priority when events coincide in one cycle: long > short clear > start. The losing event is dropped, not queued.
- Latency: a clean raw level change first sampled at edge 1 updates outputs at edge DEBOUNCE_CYCLES+3.
- Pulses: timer_clear and timer_reset are each exactly 1 cycle, never both high, never repeated while a button is held.
- Counter widths: $clog2(param+1). No wrap: the hold counter saturates.
- Reset mid-press: all state discarded. A button still held after reset release debounces to high and produces a fresh rise (start event).

Optional Feature:
- Macro: DTC_LOCK_EN.
- Defined:
  - Adds input port `ctrl_lock` (1 bit, synchronous to sys_clk).
  - While ctrl_lock=1, start/short/long events are suppressed and the hold counter is held at 0.
  - Debouncers keep running, so releasing lock mid-hold does not create a spurious fall event.
  - FSM and outputs hold their values.
- Undefined: port absent; behaviour identical to ctrl_lock=0.

Test Plan (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20):
- Reset, then idle 10 cycles → ctrl_state=00, timer_pause=1, no pulses; then hold btn_start high 10 cycles → timer_pause falls at edge 7, ctrl_state=01.
- RUNNING; btn_start pulses high for 3 cycles, 2 low, 3 high (bounce), then low → no state change, timer_pause stays 0.
- RUNNING → press start (PAUSED) → clear held 8 cycles then released → single 1-cycle timer_clear, ctrl_state=00; clear pressed while RUNNING → no timer_clear.
- Hold btn_clear 40 cycles in RUNNING → one timer_reset pulse 20 cycles after db_clear rises, ctrl_state=00, timer_pause=1; no timer_clear on release.
- btn_start and btn_clear raw rise on the same cycle in PAUSED, clear released after 8 cycles → start event dropped by priority: state stays PAUSED until the short clear sends it to IDLE with a timer_clear pulse.
- Assert rst_b low mid long-press (hold count 15) → outputs return to reset values asynchronously; after release with btn_clear still held, timer_reset fires only after 20 fresh debounced cycles.
